// File: rtl/matrix_reduce.sv
// Column-wise reduction of a ROWS x COLS signed matrix: mean, saturated sum, max or min.
// One element is consumed per cycle; each column result is registered in a WRITE cycle.
module matrix_reduce #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 16,
  parameter int COLS   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] matrix_in  [ROWS][COLS],
  output logic signed [DATA_W-1:0] matrix_out [COLS],
  output logic                     busy,
  output logic                     done
);

  localparam int LOG2R = $clog2(ROWS);
  localparam int ACC_W = DATA_W + LOG2R;
  localparam int RW    = LOG2R;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);

  localparam logic signed [ACC_W:0] SAT_HI = {{(LOG2R + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_LO = {{(LOG2R + 2){1'b1}}, {(DATA_W - 1){1'b0}}};
  localparam logic signed [ACC_W:0] HALF   = (ACC_W + 1)'(ROWS / 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACC   = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               mode_q, mode_d;
  logic [RW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [DATA_W-1:0] out_q [COLS];
  logic signed [DATA_W-1:0] out_d [COLS];
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic signed [DATA_W-1:0] elem;
  logic signed [ACC_W-1:0]  elem_x;
  logic signed [ACC_W-1:0]  combined;
  logic signed [ACC_W:0]    sum_x;
  logic signed [ACC_W:0]    rounded;
  logic signed [ACC_W:0]    shifted;
  logic signed [DATA_W-1:0] result;

  function automatic logic signed [DATA_W-1:0] clamp(input logic signed [ACC_W:0] v);
    logic signed [ACC_W:0] r;
    if (v > SAT_HI) begin
      r = SAT_HI;
    end else if (v < SAT_LO) begin
      r = SAT_LO;
    end else begin
      r = v;
    end
    return r[DATA_W-1:0];
  endfunction

  // Datapath: current element, accumulator update and per-mode column result.
  always_comb begin
    elem    = matrix_in[row_q][col_q];
    elem_x  = {{LOG2R{elem[DATA_W-1]}}, elem};
    sum_x   = {acc_q[ACC_W-1], acc_q};
    rounded = sum_x + HALF;
    shifted = rounded >>> LOG2R;
    case (mode_q)
      2'd2:    combined = (elem_x > acc_q) ? elem_x : acc_q;
      2'd3:    combined = (elem_x < acc_q) ? elem_x : acc_q;
      default: combined = acc_q + elem_x;
    endcase
    case (mode_q)
      2'd0:    result = clamp(shifted);
      2'd1:    result = clamp(sum_x);
      default: result = acc_q[DATA_W-1:0];
    endcase
  end

  // Next-state logic; abort wins over everything else while busy.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    row_d   = row_q;
    col_d   = col_q;
    acc_d   = acc_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          mode_d  = mode;
          row_d   = '0;
          col_d   = '0;
          state_d = S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACC: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          acc_d = (row_q == '0) ? elem_x : combined;
          if (row_q == ROW_LAST) begin
            row_d   = '0;
            state_d = S_WRITE;
          end else begin
            row_d = row_q + ROW_ONE;
          end
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          out_d[col_q] = result;
          if (col_q == COL_LAST) begin
            state_d = S_DONE;
          end else begin
            col_d   = col_q + COL_ONE;
            state_d = S_ACC;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= 2'd0;
      row_q   <= '0;
      col_q   <= '0;
      acc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        out_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_q   <= col_d;
      acc_q   <= acc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign matrix_out = out_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_matrix_reduce.sv
// Randomized self-checking bench for matrix_reduce with a cycle-level behavioural model.
module tb_matrix_reduce;

  localparam int DW    = 8;
  localparam int R     = 16;
  localparam int C     = 16;
  localparam int LOG2R = 4;
  localparam int PER   = R + 1;
  localparam int LAST  = C * PER;
  localparam int MAXV  = (1 << (DW - 1)) - 1;
  localparam int MINV  = -(1 << (DW - 1));

  logic                 clk;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic [1:0]           mode;
  logic signed [DW-1:0] mat  [R][C];
  logic signed [DW-1:0] mout [C];
  logic                 busy;
  logic                 done;

  int checks = 0;
  int errors = 0;

  bit m_active;
  int m_t;
  int exp_out [C];
  int new_val [C];

  matrix_reduce #(.DATA_W(DW), .ROWS(R), .COLS(C)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
    .matrix_in(mat), .matrix_out(mout), .busy(busy), .done(done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp8(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Reference result of one column straight from the arithmetic definition of each mode.
  function automatic int model_col(input int m, input int c);
    int s;
    s = int'(mat[0][c]);
    for (int r = 1; r < R; r++) begin
      case (m)
        2:       if (int'(mat[r][c]) > s) s = int'(mat[r][c]);
        3:       if (int'(mat[r][c]) < s) s = int'(mat[r][c]);
        default: s = s + int'(mat[r][c]);
      endcase
    end
    if (m == 0) s = (s + R / 2) >>> LOG2R;
    return clamp8(s);
  endfunction

  // Model: column c lands (c+1)*PER edges after the start edge, done at LAST.
  initial begin
    m_active = 1'b0;
    m_t = 0;
    for (int c = 0; c < C; c++) exp_out[c] = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_active = 1'b0;
        m_t = 0;
        for (int c = 0; c < C; c++) exp_out[c] = 0;
      end else begin
        if (m_active) begin
          if (abort) begin
            m_active = 1'b0;
          end else begin
            m_t++;
            if ((m_t % PER) == 0 && m_t / PER >= 1 && m_t / PER <= C)
              exp_out[m_t / PER - 1] = new_val[m_t / PER - 1];
            if (m_t > LAST) m_active = 1'b0;
          end
        end else if (start && !abort) begin
          m_active = 1'b1;
          m_t = 0;
          for (int c = 0; c < C; c++) new_val[c] = model_col(int'(mode), c);
        end
        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(m_active && m_t == LAST));
        for (int c = 0; c < C; c++) chk($sformatf("mout[%0d]", c), int'(mout[c]), exp_out[c]);
      end
    end
  end

  task automatic run_op(input logic [1:0] m, input int abort_at, input int restart_at,
                        output int lat, output int busy_n, output int done_n);
    lat = 0;
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    #2;
    mode  = m;
    start = 1'b1;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      if (done) begin
        done_n++;
        if (lat == 0) lat = n;
      end else if (busy && lat == 0) begin
        busy_n++;
      end
      #2;
      start = 1'b0;
      abort = 1'b0;
      if (n == restart_at) start = 1'b1;
      if (n == abort_at) abort = 1'b1;
    end
  endtask

  task automatic fill_random();
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        mat[r][c] = DW'($urandom);
  endtask

  int lat, bn, dn;
  int prev [C];
  int nxt  [C];

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode = 2'd0;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        mat[r][c] = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    for (int c = 0; c < C; c++) chk("reset_out", int'(mout[c]), 0);
    #2 rst = 1'b0;

    // Mean of a column filled with c-8 is c-8; latency and busy length.
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        mat[r][c] = DW'(c - 8);
    run_op(2'd0, 0, 0, lat, bn, dn);
    chk("latency", lat, 273);
    chk("busy_cycles", bn, 272);
    chk("done_count", dn, 1);
    for (int c = 0; c < C; c++) chk("mean_const", int'(mout[c]), c - 8);

    // Mean rounding: half up.
    fill_random();
    for (int r = 0; r < R; r++) begin
      mat[r][0] = (r < 8) ? 8'sd1 : 8'sd0;
      mat[r][1] = (r < 8) ? -8'sd1 : 8'sd0;
    end
    run_op(2'd0, 0, 0, lat, bn, dn);
    chk("round_pos", int'(mout[0]), 1);
    chk("round_neg", int'(mout[1]), 0);

    // Saturated sum.
    fill_random();
    for (int r = 0; r < R; r++) begin
      mat[r][0] = 8'sd100;
      mat[r][1] = -8'sd100;
      mat[r][2] = ((r % 2) == 0) ? 8'sd1 : -8'sd1;
    end
    run_op(2'd1, 0, 0, lat, bn, dn);
    chk("sat_hi", int'(mout[0]), 127);
    chk("sat_lo", int'(mout[1]), -128);
    chk("sat_alt", int'(mout[2]), 0);

    // Max and min at the extremes of the range.
    fill_random();
    for (int r = 0; r < R; r++) mat[r][0] = 8'sd0;
    mat[0][0] = -8'sd128;
    mat[1][0] = 8'sd5;
    mat[2][0] = 8'sd127;
    run_op(2'd2, 0, 0, lat, bn, dn);
    chk("max", int'(mout[0]), 127);
    run_op(2'd3, 0, 0, lat, bn, dn);
    chk("min", int'(mout[0]), -128);

    // Random matrices in every mode, checked cycle by cycle by the model.
    for (int k = 0; k < 8; k++) begin
      fill_random();
      run_op(2'(k % 4), 0, 0, lat, bn, dn);
      chk("rand_done_count", dn, 1);
    end

    // Abort during column 3 accumulation.
    for (int c = 0; c < C; c++) prev[c] = exp_out[c];
    fill_random();
    for (int c = 0; c < C; c++) nxt[c] = model_col(1, c);
    run_op(2'd1, 58, 0, lat, bn, dn);
    chk("abort_done_count", dn, 0);
    for (int c = 0; c < C; c++)
      chk($sformatf("abort_col%0d", c), int'(mout[c]), (c < 3) ? nxt[c] : prev[c]);
    run_op(2'd1, 0, 0, lat, bn, dn);
    chk("after_abort_done", dn, 1);
    chk("after_abort_lat", lat, 273);

    // Start while busy is ignored.
    fill_random();
    run_op(2'd0, 0, 100, lat, bn, dn);
    chk("restart_done_count", dn, 1);
    chk("restart_lat", lat, 273);

    // Reset mid-operation, then a fresh reduction.
    fill_random();
    @(negedge clk);
    #2;
    mode = 2'd2;
    start = 1'b1;
    @(negedge clk);
    #2;
    start = 1'b0;
    repeat (99) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    for (int c = 0; c < C; c++) chk("rst_out", int'(mout[c]), 0);
    @(negedge clk);
    #2 rst = 1'b0;
    fill_random();
    run_op(2'd3, 0, 0, lat, bn, dn);
    chk("post_rst_lat", lat, 273);
    chk("post_rst_done", dn, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
